// File: rtl/bcd7_pkg.sv
// bcd7_pkg: bus field offsets, segment pattern table and frame-assembly state encoding
// shared by the BCD7 scan decoder and its segment lookup.
package bcd7_pkg;
    localparam int SEL_LSB = 8;
    localparam int SEL_W   = 4;
    localparam int DP_BIT  = 7;
    localparam int SEG_W   = 7;

    // Index n holds the {g..a} pattern that displays hex digit n.
    localparam logic [0:15][6:0] SEG_TABLE = {
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    typedef enum logic [1:0] {IDLE, COLLECT, COMMIT} state_t;

    typedef struct packed {
        logic [1:0] idx;
        logic [3:0] nib;
        logic       dp;
    } digit_t;
endpackage

// File: rtl/bcd7_seg_lut.sv
// bcd7_seg_lut: maps a 7-bit segment pattern back to its hex nibble; unknown patterns
// give nibble 0 and raise bad_o.
module bcd7_seg_lut
    import bcd7_pkg::*;
(
    input  logic [SEG_W-1:0] seg_i,
    output logic [3:0]       nib_o,
    output logic             bad_o
);
    always_comb begin
        nib_o = '0;
        bad_o = 1'b1;
        for (int i = 0; i < 16; i++)
            if (seg_i == SEG_TABLE[i]) begin
                nib_o = 4'(i);
                bad_o = 1'b0;
            end
    end
endmodule

// File: rtl/bcd7_scan_decoder.sv
// bcd7_scan_decoder: glitch-filtered monitor of a multiplexed BCD7 bus, assembling 4-digit frames.
// Define BCD7_DEC_CHANGE_ONLY_EN to pulse value_valid only when the committed content changes.
module bcd7_scan_decoder
    import bcd7_pkg::*;
#(
    parameter int STABLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter bit SEG_ACTIVE_LOW = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [11:0] bcd7_in,
    output logic [15:0] value,
    output logic [3:0]  dp,
    output logic        value_valid,
    output logic        seg_err,
    output logic        stale
);
    logic [11:0] smp_q, prev_q;
    logic [7:0] run_q, run_d;
    logic [SEL_W-1:0] sel;
    logic same, acc, bad, fire, ev_v;
    logic [3:0] nib;
    digit_t cur, ev, skid_q, skid_d;
    logic skid_v_q, skid_v_d;
    state_t state_q, state_d;
    logic [3:0] mask_q, mask_d, sdp_q, sdp_d, dp_q;
    logic [15:0] shadow_q, shadow_d, tmo_q, tmo_d, value_q;
    logic stale_q, stale_d, valid_q, err_q;

    assign sel   = smp_q[SEL_LSB +: SEL_W];
    assign same  = smp_q == prev_q;
    assign run_d = !same ? 8'd1 : (run_q == 8'hFF ? run_q : run_q + 8'd1);
    // A saturated run keeps reporting the threshold, so only the arrival at it accepts.
    assign acc   = $onehot(sel) && run_d == 8'(STABLE_CYCLES) && (!same || run_q != 8'(STABLE_CYCLES));

    bcd7_seg_lut u_lut (.seg_i(smp_q[SEG_W-1:0]), .nib_o(nib), .bad_o(bad));

    assign cur  = {sel[3] | sel[2], sel[3] | sel[1], nib, smp_q[DP_BIT]};
    assign ev_v = state_q != COMMIT && (skid_v_q || acc);
    assign ev   = skid_v_q ? skid_q : cur;

    always_comb begin
        skid_v_d = state_q == COMMIT ? skid_v_q || acc : skid_v_q && acc;
        skid_d   = acc && (state_q == COMMIT ? !skid_v_q : skid_v_q) ? cur : skid_q;
        state_d  = state_q;
        mask_d   = mask_q;
        shadow_d = shadow_q;
        sdp_d    = sdp_q;
        tmo_d    = tmo_q;
        stale_d  = stale_q;
        if (ev_v) begin
            shadow_d[{ev.idx, 2'b00} +: 4] = ev.nib;
            sdp_d[ev.idx]  = ev.dp;
            mask_d[ev.idx] = 1'b1;
        end
        case (state_q)
            IDLE: state_d = ev_v ? COLLECT : IDLE;
            COLLECT: begin
                tmo_d = ev_v ? '0 : (tmo_q == 16'hFFFF ? tmo_q : tmo_q + 16'd1);
                if (mask_d == 4'hF)
                    state_d = COMMIT;
                else if (!ev_v && tmo_d == 16'(TIMEOUT_CYCLES)) begin
                    state_d = IDLE;
                    mask_d  = '0;
                    tmo_d   = '0;
                    stale_d = 1'b1;
                end
            end
            default: begin
                state_d = COLLECT;
                mask_d  = '0;
                tmo_d   = '0;
                stale_d = 1'b0;
            end
        endcase
    end

`ifdef BCD7_DEC_CHANGE_ONLY_EN
    logic done_q;
    always_ff @(posedge clk)
        done_q <= !reset ? 1'b0 : done_q | (state_q == COMMIT);
    assign fire = state_q == COMMIT && (!done_q || {sdp_q, shadow_q} != {dp_q, value_q});
`else
    assign fire = state_q == COMMIT;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            smp_q    <= '0;
            prev_q   <= '0;
            run_q    <= '0;
            skid_q   <= '0;
            skid_v_q <= 1'b0;
            state_q  <= IDLE;
            mask_q   <= '0;
            shadow_q <= '0;
            sdp_q    <= '0;
            tmo_q    <= '0;
            stale_q  <= 1'b1;
            value_q  <= '0;
            dp_q     <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            smp_q    <= {bcd7_in[11:8], bcd7_in[7:0] ^ {8{SEG_ACTIVE_LOW}}};
            prev_q   <= smp_q;
            run_q    <= run_d;
            skid_q   <= skid_d;
            skid_v_q <= skid_v_d;
            state_q  <= state_d;
            mask_q   <= mask_d;
            shadow_q <= shadow_d;
            sdp_q    <= sdp_d;
            tmo_q    <= tmo_d;
            stale_q  <= stale_d;
            valid_q  <= fire;
            err_q    <= err_q | (acc & bad);
            if (state_q == COMMIT) begin
                value_q <= shadow_q;
                dp_q    <= sdp_q;
            end
        end
    end

    assign value       = value_q;
    assign dp          = dp_q;
    assign value_valid = valid_q;
    assign seg_err     = err_q;
    assign stale       = stale_q;
endmodule

// File: tb/tb_bcd7_scan_decoder.sv
// tb_bcd7_scan_decoder: table-driven frame vectors plus hand-written glitch, timeout,
// repeat-frame and mid-frame-reset sequences for bcd7_scan_decoder.
module tb_bcd7_scan_decoder;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic [11:0] bcd7_in = '0;
    logic [15:0] value;
    logic [3:0] dp;
    logic value_valid, seg_err, stale;
    int total = 0;
    int bad = 0;
    int pulses = 0;
    int base;

    typedef struct packed {
        logic [3:0][7:0] segs;
        logic [15:0]     val;
        logic [3:0]      dpx;
        logic            err;
    } vec_t;
    vec_t vecs [9];

    bcd7_scan_decoder dut (
        .clk(clk), .reset(reset), .bcd7_in(bcd7_in), .value(value), .dp(dp),
        .value_valid(value_valid), .seg_err(seg_err), .stale(stale)
    );

    always #5 clk = ~clk;
    always @(negedge clk) if (value_valid) pulses <= pulses + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        bcd7_in = '0;
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic show(input int d, input logic [7:0] seg, input int n);
        bcd7_in = {4'(1 << d), seg};
        repeat (n) @(negedge clk);
    endtask

    task automatic scan(input logic [3:0][7:0] s);
        for (int d = 0; d < 4; d++) show(d, s[d], 8);
        bcd7_in = '0;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        vecs[0] = '{segs: {8'h66, 8'h4F, 8'h5B, 8'h06}, val: 16'h4321, dpx: 4'b0000, err: 1'b0};
        vecs[1] = '{segs: {8'h77, 8'h6F, 8'h7F, 8'h3F}, val: 16'hA980, dpx: 4'b0000, err: 1'b0};
        vecs[2] = '{segs: {8'h79, 8'h5E, 8'h39, 8'h7C}, val: 16'hEDCB, dpx: 4'b0000, err: 1'b0};
        vecs[3] = '{segs: {8'h6D, 8'h07, 8'h7D, 8'h71}, val: 16'h576F, dpx: 4'b0000, err: 1'b0};
        vecs[4] = '{segs: {8'h66, 8'hCF, 8'h5B, 8'h86}, val: 16'h4321, dpx: 4'b0101, err: 1'b0};
        vecs[5] = '{segs: {8'h66, 8'hFF, 8'h5B, 8'h06}, val: 16'h4821, dpx: 4'b0100, err: 1'b0};
        vecs[6] = '{segs: {8'h66, 8'h4F, 8'h08, 8'h06}, val: 16'h4301, dpx: 4'b0000, err: 1'b1};
        vecs[7] = '{segs: {8'h66, 8'h4F, 8'h00, 8'h06}, val: 16'h4301, dpx: 4'b0000, err: 1'b1};
        vecs[8] = '{segs: {8'h66, 8'h00, 8'h5B, 8'h06}, val: 16'h4021, dpx: 4'b0000, err: 1'b1};

        repeat (2) @(negedge clk);
        check("reset value", 32'(value), 32'h0);
        check("reset dp", 32'(dp), 32'h0);
        check("reset valid", 32'(value_valid), 32'h0);
        check("reset seg_err", 32'(seg_err), 32'h0);
        check("reset stale", 32'(stale), 32'h1);
        reset = 1'b1;

        for (int i = 0; i < 9; i++) begin
            do_reset();
            base = pulses;
            scan(vecs[i].segs);
            check($sformatf("v%0d value", i), 32'(value), 32'(vecs[i].val));
            check($sformatf("v%0d dp", i), 32'(dp), 32'(vecs[i].dpx));
            check($sformatf("v%0d seg_err", i), 32'(seg_err), 32'(vecs[i].err));
            check($sformatf("v%0d pulses", i), 32'(pulses - base), 32'd1);
            check($sformatf("v%0d stale", i), 32'(stale), 32'h0);
        end

        // seg_err is sticky across a following good frame
        scan({8'h66, 8'h4F, 8'h5B, 8'h06});
        check("sticky seg_err", 32'(seg_err), 32'h1);
        check("sticky value", 32'(value), 32'h4321);

        // digit 1 glitches for only 2 cycles: no commit until a full pass
        do_reset();
        base = pulses;
        show(0, 8'h06, 8);
        show(1, 8'h5B, 2);
        show(2, 8'h4F, 8);
        show(3, 8'h66, 8);
        bcd7_in = '0;
        repeat (4) @(negedge clk);
        check("glitch no commit", 32'(pulses - base), 32'd0);
        check("glitch value held", 32'(value), 32'h0);
        scan({8'h66, 8'h4F, 8'h5B, 8'h06});
        check("glitch full pass pulses", 32'(pulses - base), 32'd1);
        check("glitch full pass value", 32'(value), 32'h4321);

        // partial frame then silence: timeout drops it and raises stale
        do_reset();
        base = pulses;
        scan({8'h66, 8'h4F, 8'h5B, 8'h06});
        show(0, 8'h7F, 8);
        show(1, 8'h7F, 8);
        show(2, 8'h7F, 8);
        bcd7_in = '0;
        repeat (4000) @(negedge clk);
        check("pre-timeout stale", 32'(stale), 32'h0);
        repeat (200) @(negedge clk);
        check("timeout stale", 32'(stale), 32'h1);
        check("timeout value held", 32'(value), 32'h4321);
        show(3, 8'h66, 8);
        bcd7_in = '0;
        repeat (4) @(negedge clk);
        check("timeout mask dropped", 32'(pulses - base), 32'd1);
        scan({8'h7F, 8'h07, 8'h7D, 8'h6D});
        check("after timeout pulses", 32'(pulses - base), 32'd2);
        check("after timeout value", 32'(value), 32'h4765);
        check("after timeout stale", 32'(stale), 32'h0);

        // identical frame twice
        do_reset();
        base = pulses;
        scan({8'h66, 8'h4F, 8'h5B, 8'h06});
        scan({8'h66, 8'h4F, 8'h5B, 8'h06});
`ifdef BCD7_DEC_CHANGE_ONLY_EN
        check("repeat frame pulses", 32'(pulses - base), 32'd1);
`else
        check("repeat frame pulses", 32'(pulses - base), 32'd2);
`endif
        check("repeat frame value", 32'(value), 32'h4321);

        // one-cycle reset after two accepted digits
        show(0, 8'h7F, 8);
        show(1, 8'h5B, 8);
        bcd7_in = '0;
        reset = 1'b0;
        @(negedge clk);
        check("midreset value", 32'(value), 32'h0);
        check("midreset dp", 32'(dp), 32'h0);
        check("midreset valid", 32'(value_valid), 32'h0);
        check("midreset seg_err", 32'(seg_err), 32'h0);
        check("midreset stale", 32'(stale), 32'h1);
        reset = 1'b1;
        base = pulses;
        scan({8'h7D, 8'h6D, 8'hDB, 8'h7F});
        check("post reset pulses", 32'(pulses - base), 32'd1);
        check("post reset value", 32'(value), 32'h6528);
        check("post reset dp", 32'(dp), 32'b0010);
        check("post reset stale", 32'(stale), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/bcd7_scan_decoder.md
Name: bcd7_scan_decoder

Overview:
- Receive-side counterpart of the CPU's 12-bit multiplexed seven-segment output (BCD7).
- Samples the scanned digit-select and segment lines and filters out glitches.
- Decodes each digit pattern back to a hex nibble and assembles 4-digit frames into a 16-bit value.
- Used as a self-checking monitor in CPU benches and as an on-board loopback checker; sits directly on the CPU BCD7 bus.

Parameters:
- STABLE_CYCLES, 4: consecutive identical samples needed before a digit is accepted (1..255).
- TIMEOUT_CYCLES, 4096: cycles with no accepted digit before the partial frame is dropped (2..65535).
- SEG_ACTIVE_LOW, 0: 1 = segment bits [7:0] are active-low and are inverted before decoding.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-low reset
- bcd7_in  input  12  [11:8] one-hot digit select (bit 8 = digit 0, least significant); [7:0] {dp,g,f,e,d,c,b,a}
- value  output  16  last committed frame; digit n in bits [4n+3:4n]
- dp  output  4  decimal-point bit of each digit in the committed frame
- value_valid  output  1  one-cycle pulse when a frame is committed
- seg_err  output  1  sticky; set when an accepted digit carries an undecodable pattern
- stale  output  1  high while no frame has been committed within TIMEOUT_CYCLES

Behaviour:
- Reset (reset==0 at a clk edge):
  - value=0, dp=0, value_valid=0, seg_err=0, stale=1.
  - Frame mask cleared, counters cleared, state=IDLE.
  - Applies mid-frame with no partial commit.
- Input path: bcd7_in registered once (1-cycle latency). Segment field inverted if SEG_ACTIVE_LOW.
- Stability filter:
  - Compare the registered sample with the previous one. Equal: the run counter increments, saturating at 255. Different: the counter reloads to 1.
  - A digit is accepted on the cycle the counter reaches STABLE_CYCLES, once per run.
  - Sample ignored if the select field is not one-hot (zero or multiple bits set); the run counter still tracks it.
- Decode table (a=bit0), [6:0] to nibble:
  - 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07
  - 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71
  - Any other pattern: nibble 0 and seg_err set (sticky until reset).
- States:
  - IDLE: wait for the first accepted digit, then go to COLLECT with that digit stored and its mask bit set.
  - COLLECT: each accepted digit writes its shadow nibble and dp and sets its mask bit; a repeat of an already-set digit overwrites it. When mask==4'b1111, go to COMMIT.
  - COMMIT (one cycle): shadow copied to value/dp, value_valid=1, stale=0, mask cleared, timeout counter cleared, then back to COLLECT.
- Timeout:
  - The counter runs in COLLECT and increments every cycle; it clears on each accepted digit and on commit.
  - Reaching TIMEOUT_CYCLES: mask cleared, stale=1, state=IDLE.
  - value is held, not cleared.
- Simultaneous events:
  - An accepted digit in the COMMIT cycle is held in a 1-entry skid register and applied in the following cycle.
  - An accept takes priority over a timeout in the same cycle.
- Widths: run counter 8 bits, timeout counter 16 bits; both saturate, neither wraps.

Optional Feature:
- Macro: BCD7_DEC_CHANGE_ONLY_EN.
- Defined: COMMIT pulses value_valid only if {dp,value} differs from the previously committed content; otherwise the commit is silent. The first commit after reset always pulses.
- Undefined: every completed frame pulses value_valid.

Decomposition:
- Package bcd7_pkg:
  - select and segment field offsets.
  - 16-entry segment-pattern constant table.
  - state encoding (IDLE/COLLECT/COMMIT).
- Sub-module bcd7_seg_lut: combinational 7-bit pattern in, 4-bit nibble plus invalid flag out; instantiated once.

Test Plan:
- Scan digits 0..3 with segments 06,5B,4F,66 (dp=0), each held 8 cycles -> value=16'h4321, one value_valid pulse, stale=0, seg_err=0.
- Same scan with digit 1 shown for only 2 cycles in the first pass, then a correct full pass -> no commit until the full pass; value=16'h4321.
- Digit 2 shows pattern 8'h00 -> seg_err=1 and stays 1; committed nibble 2 = 0.
- Scan digits 0..2 only, then hold the select field at 0 for 4096+ cycles -> stale=1, state IDLE, value unchanged.
- Repeat an identical 4321 frame twice: with BCD7_DEC_CHANGE_ONLY_EN one pulse; without it, two pulses.
- Assert reset for 1 cycle mid-frame after two accepted digits -> all outputs at reset values; the next full frame commits correctly.
